// File: rtl/uart_pattern_gen_pkg.sv
// Shared constants, mode encodings and enumerations for the ASCII pattern generator.
// MODE 3 is accepted on the port and behaves exactly like wrap.
package uart_pattern_gen_pkg;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;

  localparam logic [1:0] MODE_SAT  = 2'd0;
  localparam logic [1:0] MODE_WRAP = 2'd1;
  localparam logic [1:0] MODE_ONCE = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARM      = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_WAIT_ACC = 3'd3,
    ST_WAIT_TX  = 3'd4,
    ST_GAP      = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    PH_PAY = 2'd0,
    PH_CR  = 2'd1,
    PH_LF  = 2'd2
  } phase_e;

  function automatic logic is_wrap(input logic [1:0] mode);
    return (mode == MODE_WRAP) || (mode == 2'd3);
  endfunction

endpackage

// File: rtl/uart_pattern_gen_sel.sv
// Character selector: payload counter, line position, CR/LF insertion and end-of-range decision.
// The next payload is computed at the advance that triggers CR/LF, so it is already waiting after LF.
module uart_pattern_gen_sel
  import uart_pattern_gen_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] FIRST_CHAR = 8'h30,
  parameter logic [DATA_W-1:0] LAST_CHAR  = 8'h39,
  parameter int                LINE_LEN   = 10,
  parameter int                CNT_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_restart,
  input  logic              i_advance,
  input  logic [1:0]        i_mode,
  output logic [DATA_W-1:0] o_char,
  output logic              o_done,
  output logic              o_finish
);

  phase_e            r_phase, w_phase_nxt;
  logic [DATA_W-1:0] r_pay, w_pay_nxt, r_char, w_char_nxt;
  logic [CNT_W-1:0]  r_line_pos, w_line_nxt;
  logic              r_done, r_done_pend, w_pend_nxt, w_finish;
  logic              w_at_last, w_line_end;

  assign w_at_last  = (r_pay == LAST_CHAR);
  assign w_line_end = (LINE_LEN != 0) && (r_line_pos == CNT_W'(LINE_LEN - 1));

  // Next selector contents for an advance; a single pass finishing on a line end defers DONE past LF.
  always_comb begin
    w_phase_nxt = r_phase;
    w_pay_nxt   = r_pay;
    w_line_nxt  = r_line_pos;
    w_pend_nxt  = r_done_pend;
    w_finish    = 1'b0;
    case (r_phase)
      PH_PAY: begin
        w_line_nxt = r_line_pos + CNT_W'(1);
        if (!w_at_last) begin
          w_pay_nxt = r_pay + DATA_W'(1);
        end else if (is_wrap(i_mode)) begin
          w_pay_nxt = FIRST_CHAR;
        end else begin
          w_pay_nxt = r_pay;
        end
        if (w_line_end) begin
          w_phase_nxt = PH_CR;
          w_pend_nxt  = w_at_last && (i_mode == MODE_ONCE);
        end else begin
          w_finish    = w_at_last && (i_mode == MODE_ONCE);
        end
      end
      PH_CR: begin
        w_phase_nxt = PH_LF;
      end
      PH_LF: begin
        w_phase_nxt = PH_PAY;
        w_line_nxt  = '0;
        w_finish    = r_done_pend;
        w_pend_nxt  = 1'b0;
      end
      default: begin
        w_phase_nxt = PH_PAY;
      end
    endcase
  end

  // Character presented on the next cycle, derived from the next phase.
  always_comb begin
    case (w_phase_nxt)
      PH_CR:   w_char_nxt = DATA_W'(ASCII_CR);
      PH_LF:   w_char_nxt = DATA_W'(ASCII_LF);
      default: w_char_nxt = w_pay_nxt;
    endcase
  end

  // Selector state; restart always beats a simultaneous advance.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase     <= PH_PAY;
      r_pay       <= FIRST_CHAR;
      r_char      <= FIRST_CHAR;
      r_line_pos  <= '0;
      r_done      <= 1'b0;
      r_done_pend <= 1'b0;
    end else if (i_restart) begin
      r_phase     <= PH_PAY;
      r_pay       <= FIRST_CHAR;
      r_char      <= FIRST_CHAR;
      r_line_pos  <= '0;
      r_done      <= 1'b0;
      r_done_pend <= 1'b0;
    end else if (i_advance) begin
      r_phase     <= w_phase_nxt;
      r_pay       <= w_pay_nxt;
      r_char      <= w_char_nxt;
      r_line_pos  <= w_line_nxt;
      r_done_pend <= w_pend_nxt;
      if (w_finish) begin
        r_done <= 1'b1;
      end
    end
  end

  assign o_char   = r_char;
  assign o_done   = r_done;
  assign o_finish = w_finish;

endmodule

// File: rtl/uart_pattern_gen.sv
// ASCII test-pattern source for uart_send: handshake FSM, inter-character gap and issue counter.
// START arriving while a character is in flight is held until that character completes.
module uart_pattern_gen
  import uart_pattern_gen_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] FIRST_CHAR = 8'h30,
  parameter logic [DATA_W-1:0] LAST_CHAR  = 8'h39,
  parameter int                LINE_LEN   = 10,
  parameter int                GAP_CYCLES = 0,
  parameter int                CNT_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic [1:0]        i_mode,
  input  logic              i_start,
  input  logic              i_sender_idle,
  output logic [DATA_W-1:0] o_data,
  output logic              o_data_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_char_count
);

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_gap_cnt, r_count;
  logic             r_start_pend;
  logic             w_in_flight, w_tx_end, w_restart, w_advance, w_done, w_finish;

  assign w_in_flight = (r_state == ST_ISSUE) || (r_state == ST_WAIT_ACC) || (r_state == ST_WAIT_TX);
  assign w_tx_end    = (r_state == ST_WAIT_TX) && i_sender_idle;
  assign w_restart   = (i_start && !w_in_flight) || (w_tx_end && (i_start || r_start_pend));
  assign w_advance   = w_tx_end && !i_start && !r_start_pend;

  uart_pattern_gen_sel #(
    .DATA_W     (DATA_W),
    .FIRST_CHAR (FIRST_CHAR),
    .LAST_CHAR  (LAST_CHAR),
    .LINE_LEN   (LINE_LEN),
    .CNT_W      (CNT_W)
  ) u_sel (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_restart (w_restart),
    .i_advance (w_advance),
    .i_mode    (i_mode),
    .o_char    (o_data),
    .o_done    (w_done),
    .o_finish  (w_finish)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_enable && (!w_done || i_start)) w_state_nxt = ST_ARM;
        else                                  w_state_nxt = ST_IDLE;
      end
      ST_ARM: begin
        if (!i_enable)                        w_state_nxt = ST_IDLE;
        else if (!i_start && i_sender_idle)   w_state_nxt = ST_ISSUE;
        else                                  w_state_nxt = ST_ARM;
      end
      ST_ISSUE: begin
        w_state_nxt = ST_WAIT_ACC;
      end
      ST_WAIT_ACC: begin
        if (!i_sender_idle) w_state_nxt = ST_WAIT_TX;
        else                w_state_nxt = ST_WAIT_ACC;
      end
      ST_WAIT_TX: begin
        if (!i_sender_idle)              w_state_nxt = ST_WAIT_TX;
        else if (w_advance && w_finish)  w_state_nxt = ST_IDLE;
        else if (!i_enable)              w_state_nxt = ST_IDLE;
        else if (GAP_CYCLES == 0)        w_state_nxt = ST_ARM;
        else                             w_state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (!i_enable)                                               w_state_nxt = ST_IDLE;
        else if (i_start || (r_gap_cnt == CNT_W'(GAP_CYCLES - 1)))   w_state_nxt = ST_ARM;
        else                                                         w_state_nxt = ST_GAP;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode.
  always_comb begin
    o_data_ready = (r_state == ST_ISSUE);
    o_busy       = (r_state != ST_IDLE);
  end

  // Gap counter, deferred START flag and saturating issue counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gap_cnt    <= '0;
      r_start_pend <= 1'b0;
      r_count      <= '0;
    end else begin
      if (r_state == ST_GAP) r_gap_cnt <= r_gap_cnt + CNT_W'(1);
      else                   r_gap_cnt <= '0;
      if (w_tx_end)                     r_start_pend <= 1'b0;
      else if (i_start && w_in_flight)  r_start_pend <= 1'b1;
      if (i_start) begin
        r_count <= '0;
      end else if ((w_state_nxt == ST_ISSUE) && (r_state != ST_ISSUE) && (r_count != '1)) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign o_done       = w_done;
  assign o_char_count = r_count;

endmodule

// File: tb/tb_uart_pattern_gen.sv
// Self-checking bench: four generator configurations, each driven by a randomised uart_send model.
// Expected character streams come from a range/line-length arithmetic model, not from the RTL.
module tb_uart_pattern_gen;

  localparam int GAP_N = 5;

  logic        clk = 1'b0;
  logic        rst_n  [4];
  logic        enable [4];
  logic        start  [4];
  logic        sidle  [4];
  logic [1:0]  mode   [4];
  logic [7:0]  data   [4];
  logic        dready [4];
  logic        busy   [4];
  logic        done   [4];
  logic [15:0] ccount [4];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] cap_mem [4][128];
  int         cap_cnt [4][128];
  int         cap_gap [4][128];
  int         cap_n   [4];
  int         pulse_n [4];
  int         rise_cyc[4];
  int         tx_fixed[4];
  int         exp_mem [256];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_pattern_gen u_def (
    .i_clk(clk), .i_rst_n(rst_n[0]), .i_enable(enable[0]), .i_mode(mode[0]), .i_start(start[0]),
    .i_sender_idle(sidle[0]), .o_data(data[0]), .o_data_ready(dready[0]), .o_busy(busy[0]),
    .o_done(done[0]), .o_char_count(ccount[0]));

  uart_pattern_gen #(.LINE_LEN(0)) u_sat (
    .i_clk(clk), .i_rst_n(rst_n[1]), .i_enable(enable[1]), .i_mode(mode[1]), .i_start(start[1]),
    .i_sender_idle(sidle[1]), .o_data(data[1]), .o_data_ready(dready[1]), .o_busy(busy[1]),
    .o_done(done[1]), .o_char_count(ccount[1]));

  uart_pattern_gen #(.FIRST_CHAR(8'h41), .LAST_CHAR(8'h43), .LINE_LEN(2)) u_abc (
    .i_clk(clk), .i_rst_n(rst_n[2]), .i_enable(enable[2]), .i_mode(mode[2]), .i_start(start[2]),
    .i_sender_idle(sidle[2]), .o_data(data[2]), .o_data_ready(dready[2]), .o_busy(busy[2]),
    .o_done(done[2]), .o_char_count(ccount[2]));

  uart_pattern_gen #(.GAP_CYCLES(GAP_N)) u_gap (
    .i_clk(clk), .i_rst_n(rst_n[3]), .i_enable(enable[3]), .i_mode(mode[3]), .i_start(start[3]),
    .i_sender_idle(sidle[3]), .o_data(data[3]), .o_data_ready(dready[3]), .o_busy(busy[3]),
    .o_done(done[3]), .o_char_count(ccount[3]));

  // Behavioural uart_send: accepts 1..3 cycles after DATA_READY, transmits for a random or fixed time.
  for (genvar g = 0; g < 4; g++) begin : g_snd
    initial begin
      int acc_left;
      int tx_left;
      logic [7:0] held;
      acc_left = 0;
      tx_left  = 0;
      held     = 8'h00;
      sidle[g] = 1'b1;
      forever begin
        @(negedge clk);
        if (dready[g] === 1'b1) pulse_n[g] = pulse_n[g] + 1;
        if (!rst_n[g]) begin
          acc_left = 0;
          tx_left  = 0;
          sidle[g] = 1'b1;
        end else if (tx_left > 0) begin
          tx_left = tx_left - 1;
          if (tx_left == 0) begin
            sidle[g]    = 1'b1;
            rise_cyc[g] = cyc;
          end
        end else if (acc_left > 0) begin
          acc_left = acc_left - 1;
          if (acc_left == 0) begin
            checks = checks + 1;
            if (data[g] !== held) begin
              errors = errors + 1;
              $display("FAIL data_stable[%0d]: got %h expected %h", g, data[g], held);
            end
            sidle[g] = 1'b0;
            tx_left  = (tx_fixed[g] > 0) ? tx_fixed[g] : int'($urandom_range(1, 4));
          end
        end else if (dready[g] === 1'b1) begin
          held = data[g];
          if (cap_n[g] < 128) begin
            cap_mem[g][cap_n[g]] = data[g];
            cap_cnt[g][cap_n[g]] = int'(ccount[g]);
            cap_gap[g][cap_n[g]] = cyc - rise_cyc[g];
            cap_n[g] = cap_n[g] + 1;
          end
          acc_left = int'($urandom_range(1, 3));
        end
      end
    end
  end

  // Reference stream: payload index k maps to a character by mode; CR/LF after every ll payloads.
  task automatic build_exp(input int first, input int last, input int ll, input int md,
                           input int nmax, output int n);
    int k;
    int range;
    int c;
    range = last - first + 1;
    n = 0;
    k = 0;
    while (n < nmax) begin
      if (md == 2 && k >= range) break;
      if (md == 0)      c = (first + k > last) ? last : first + k;
      else if (md == 2) c = first + k;
      else              c = first + (k % range);
      exp_mem[n] = c;
      n = n + 1;
      k = k + 1;
      if (ll > 0 && (k % ll) == 0) begin
        if (n < nmax) begin exp_mem[n] = 8'h0D; n = n + 1; end
        if (n < nmax) begin exp_mem[n] = 8'h0A; n = n + 1; end
      end
    end
  endtask

  task automatic wait_caps(input int idx, input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (cap_n[idx] >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_not_busy(input int idx, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy[idx] === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    logic [7:0] firsts [4];
    firsts[0] = 8'h30; firsts[1] = 8'h30; firsts[2] = 8'h41; firsts[3] = 8'h30;
    for (int i = 0; i < 4; i++) begin
      rst_n[i] = 1'b0; enable[i] = 1'b0; start[i] = 1'b0; mode[i] = 2'd0; tx_fixed[i] = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) rst_n[i] = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks = checks + 1;
      if ({data[i], dready[i], busy[i], done[i], ccount[i]} !== {firsts[i], 1'b0, 1'b0, 1'b0, 16'd0}) begin
        errors = errors + 1;
        $display("FAIL reset[%0d]: got data=%h rdy=%b busy=%b done=%b cnt=%0d expected data=%h rest 0",
                 i, data[i], dready[i], busy[i], done[i], ccount[i], firsts[i]);
      end
    end
  endtask

  task automatic test_single_pass();
    bit ok;
    int n;
    mode[0] = 2'd2;
    enable[0] = 1'b1;
    @(negedge clk);
    checks = checks + 1;
    if (dready[0] !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL latency_edge1: got ready=%b expected 0", dready[0]);
    end
    @(negedge clk);
    checks = checks + 1;
    if (dready[0] !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL latency_edge2: got ready=%b expected 1", dready[0]);
    end
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done[0] === 1'b1) begin ok = 1'b1; break; end
    end
    checks = checks + 1;
    if (!ok) begin
      errors = errors + 1;
      $display("FAIL once_timeout: DONE never rose, expected DONE=1");
    end
    build_exp(8'h30, 8'h39, 10, 2, 256, n);
    checks = checks + 1;
    if (busy[0] !== 1'b0 || ccount[0] !== 16'(n) || cap_n[0] != n || pulse_n[0] != n) begin
      errors = errors + 1;
      $display("FAIL once_totals: got busy=%b cnt=%0d caps=%0d pulses=%0d expected busy=0 all=%0d",
               busy[0], ccount[0], cap_n[0], pulse_n[0], n);
    end
    for (int i = 0; i < n && i < cap_n[0]; i++) begin
      checks = checks + 1;
      if (cap_mem[0][i] !== exp_mem[i][7:0]) begin
        errors = errors + 1;
        $display("FAIL once_char[%0d]: got %h expected %h", i, cap_mem[0][i], exp_mem[i][7:0]);
      end
    end
    repeat (5) @(negedge clk);
    checks = checks + 1;
    if (pulse_n[0] != n || busy[0] !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL once_stays_idle: got pulses=%0d busy=%b expected %0d and 0", pulse_n[0], busy[0], n);
    end
    enable[0] = 1'b0;
  endtask

  task automatic test_saturate();
    bit ok;
    int n;
    mode[1] = 2'd0;
    enable[1] = 1'b1;
    wait_caps(1, 15, 3000, ok);
    enable[1] = 1'b0;
    wait_not_busy(1, 200, ok);
    checks = checks + 1;
    if (!ok || cap_n[1] < 15) begin
      errors = errors + 1;
      $display("FAIL sat_timeout: got caps=%0d expected >= 15 and idle", cap_n[1]);
    end
    build_exp(8'h30, 8'h39, 0, 0, cap_n[1], n);
    for (int i = 0; i < n; i++) begin
      checks = checks + 1;
      if (cap_mem[1][i] !== exp_mem[i][7:0]) begin
        errors = errors + 1;
        $display("FAIL sat_char[%0d]: got %h expected %h", i, cap_mem[1][i], exp_mem[i][7:0]);
      end
    end
    checks = checks + 1;
    if (done[1] !== 1'b0 || ccount[1] !== 16'(cap_n[1])) begin
      errors = errors + 1;
      $display("FAIL sat_state: got done=%b cnt=%0d expected done=0 cnt=%0d", done[1], ccount[1], cap_n[1]);
    end
  endtask

  task automatic test_wrap_resume();
    bit ok;
    int n;
    mode[2] = ($urandom_range(0, 1) == 0) ? 2'd1 : 2'd3;
    enable[2] = 1'b1;
    wait_caps(2, 6, 2000, ok);
    enable[2] = 1'b0;
    wait_not_busy(2, 200, ok);
    repeat ($urandom_range(1, 8)) @(negedge clk);
    enable[2] = 1'b1;
    wait_caps(2, 14, 3000, ok);
    enable[2] = 1'b0;
    wait_not_busy(2, 200, ok);
    checks = checks + 1;
    if (!ok || cap_n[2] < 14) begin
      errors = errors + 1;
      $display("FAIL wrap_timeout: got caps=%0d expected >= 14 and idle", cap_n[2]);
    end
    build_exp(8'h41, 8'h43, 2, 1, cap_n[2], n);
    for (int i = 0; i < n; i++) begin
      checks = checks + 1;
      if (cap_mem[2][i] !== exp_mem[i][7:0]) begin
        errors = errors + 1;
        $display("FAIL wrap_char[%0d]: got %h expected %h", i, cap_mem[2][i], exp_mem[i][7:0]);
      end
    end
    checks = checks + 1;
    if (ccount[2] !== 16'(cap_n[2])) begin
      errors = errors + 1;
      $display("FAIL wrap_count: got %0d expected %0d", ccount[2], cap_n[2]);
    end
  endtask

  // Idle sampled high at edge E moves WAIT_TX->GAP; GAP_N cycles, then ARM, so ISSUE lands GAP_N+2 edges on.
  task automatic test_gap();
    bit ok;
    int n;
    mode[3] = 2'd1;
    enable[3] = 1'b1;
    wait_caps(3, 8, 3000, ok);
    enable[3] = 1'b0;
    wait_not_busy(3, 200, ok);
    checks = checks + 1;
    if (!ok || cap_n[3] < 8) begin
      errors = errors + 1;
      $display("FAIL gap_timeout: got caps=%0d expected >= 8", cap_n[3]);
    end
    build_exp(8'h30, 8'h39, 10, 1, 8, n);
    for (int i = 0; i < n; i++) begin
      checks = checks + 1;
      if (cap_mem[3][i] !== exp_mem[i][7:0]) begin
        errors = errors + 1;
        $display("FAIL gap_char[%0d]: got %h expected %h", i, cap_mem[3][i], exp_mem[i][7:0]);
      end
      if (i > 0) begin
        checks = checks + 1;
        if (cap_gap[3][i] != GAP_N + 2) begin
          errors = errors + 1;
          $display("FAIL gap_cycles[%0d]: got %0d expected %0d", i, cap_gap[3][i], GAP_N + 2);
        end
      end
    end
  endtask

  task automatic test_start_mid_tx();
    bit ok;
    int base;
    tx_fixed[0] = 6;
    mode[0] = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd1;
    @(negedge clk);
    start[0] = 1'b1;
    enable[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    base = cap_n[0];
    wait_caps(0, base + 5, 2000, ok);
    checks = checks + 1;
    if (!ok || cap_mem[0][base + 4] !== 8'h34) begin
      errors = errors + 1;
      $display("FAIL start_pre: got char=%h ok=%0d expected 34", cap_mem[0][base + 4], ok);
    end
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (sidle[0] === 1'b0) begin ok = 1'b1; break; end
    end
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    checks = checks + 1;
    if (!ok || data[0] !== 8'h34 || done[0] !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL start_no_retract: got data=%h done=%b expected 34 and 0", data[0], done[0]);
    end
    wait_caps(0, base + 6, 500, ok);
    checks = checks + 1;
    if (!ok || cap_mem[0][base + 5] !== 8'h30 || cap_cnt[0][base + 5] != 1) begin
      errors = errors + 1;
      $display("FAIL start_restart: got char=%h cnt=%0d expected 30 and 1",
               cap_mem[0][base + 5], cap_cnt[0][base + 5]);
    end
    enable[0] = 1'b0;
    wait_not_busy(0, 200, ok);
    tx_fixed[0] = 0;
  endtask

  task automatic test_reset_gap();
    bit ok;
    int base;
    enable[3] = 1'b1;
    base = cap_n[3];
    wait_caps(3, base + 2, 2000, ok);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (sidle[3] === 1'b0) break;
    end
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (sidle[3] === 1'b1) begin ok = 1'b1; break; end
    end
    #2;
    rst_n[3] = 1'b0;
    #1;
    checks = checks + 1;
    if (!ok || {data[3], dready[3], busy[3], done[3], ccount[3]} !== {8'h30, 1'b0, 1'b0, 1'b0, 16'd0}) begin
      errors = errors + 1;
      $display("FAIL async_reset: got data=%h rdy=%b busy=%b done=%b cnt=%0d expected 30 and zeros",
               data[3], dready[3], busy[3], done[3], ccount[3]);
    end
    @(negedge clk);
    rst_n[3] = 1'b1;
    base = cap_n[3];
    wait_caps(3, base + 1, 500, ok);
    checks = checks + 1;
    if (!ok || cap_mem[3][base] !== 8'h30 || cap_cnt[3][base] != 1) begin
      errors = errors + 1;
      $display("FAIL reset_recover: got char=%h cnt=%0d expected 30 and 1", cap_mem[3][base], cap_cnt[3][base]);
    end
    enable[3] = 1'b0;
    wait_not_busy(3, 200, ok);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      cap_n[i] = 0; pulse_n[i] = 0; rise_cyc[i] = 0;
    end
    test_reset();
    test_single_pass();
    test_saturate();
    test_wrap_resume();
    test_gap();
    test_start_mid_tx();
    test_reset_gap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
